alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU_alu instance between two requesters, e.g. the EX stage (port 0) and the branch/address unit (port 1).
- Round-robin arbitration with a valid/ready handshake on each request port.
- Drives the external ALU's aluOP/operand inputs and captures the ALU result into a single response register with its own valid/ready handshake.
- Sits in the EX stage between the issuing logic and the shared ALU.

Parameters:
OPERAND_WIDTH, 32, width of operands and result; must match the ALU instance.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  4  ALU opcode from requester 0
req0_a  input  OPERAND_WIDTH  operand1 from requester 0
req0_b  input  OPERAND_WIDTH  operand2 from requester 0
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_op  input  4  ALU opcode from requester 1
req1_a  input  OPERAND_WIDTH  operand1 from requester 1
req1_b  input  OPERAND_WIDTH  operand2 from requester 1
alu_op  output  4  to ALU aluOP
alu_operand1  output  OPERAND_WIDTH  to ALU operand1
alu_operand2  output  OPERAND_WIDTH  to ALU operand2
alu_result  input  OPERAND_WIDTH  from ALU result
rsp_valid  output  1  response register holds a result
rsp_ready  input  1  consumer accepts the response
rsp_id  output  1  requester that owns the response
rsp_result  output  OPERAND_WIDTH  captured result
rsp_illegal  output  1  opcode was outside 4'b0000-4'b1001

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n is sampled synchronously, active low, and takes priority over all other updates.
  - Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_illegal=0, priority pointer=0 (requester 0 preferred).
  - Reset mid-operation drops any pending response; no accept is reported in the reset cycle.
- Response register states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - can_accept = !rsp_valid || rsp_ready.
- Arbitration (combinational, same cycle):
  - Candidates are requesters with reqN_valid=1. Grant only if can_accept and rst_n=1.
  - If both are valid, grant the requester selected by the pointer. If one is valid, grant it.
  - reqN_ready=1 only for the granted requester. At most one ready per cycle.
  - The ready path depends on valid and rsp_ready, never on any ready output (no comb loops).
- ALU drive:
  - On grant, alu_op/alu_operand1/alu_operand2 equal the granted requester's op/a/b.
  - With no grant, all three are driven to 0.
- Capture on the clock edge when a grant occurs:
  - rsp_valid<=1, rsp_id<=granted index, rsp_result<=alu_result.
  - rsp_illegal<=(op>4'b1001). For an illegal op, rsp_result<=0 regardless of alu_result.
  - Pointer <= ~granted index. The pointer is unchanged when there is no grant.
- Latency and throughput:
  - Result is visible 1 cycle after accept.
  - Sustained throughput is 1 op/cycle while rsp_ready stays high.
- Drain:
  - FULL with rsp_ready=1 and no new grant: rsp_valid<=0. Result, id and illegal hold their last values.
- Backpressure:
  - FULL with rsp_ready=0: no grant. Both readys are 0. Response outputs hold stable.
- Simultaneous drain and accept:
  - Response register is overwritten with the new result; rsp_valid stays 1.
- Requester protocol:
  - Once reqN_valid=1, op/a/b must stay stable until reqN_ready=1.
  - The block does not check this; the bench asserts it on stimulus.
- Fairness:
  - With both requesters continuously valid and rsp_ready=1, grants alternate 0,1,0,1…
  - No requester waits more than 1 grant of the other.
- Arithmetic: all arithmetic is done by the external ALU. This block performs no width conversion.

Test Plan:
- Single op: after reset, req0 add a=5, b=7 → req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_illegal=0.
- Contention: req0 sub 10-3 and req1 sltu a=1, b=2, both valid continuously with rsp_ready=1 → grants 0,1,0,1; responses 7(id0), 1(id1), 7, 1 on consecutive cycles.
- Backpressure: rsp_ready=0 for 3 cycles with the response FULL → both readys 0; rsp_result held; on rsp_ready=1, new grant that cycle and next result 1 cycle later.
- Illegal op: req1 op=4'b1100, a=0xFFFF_FFFF, b=1 → rsp_id=1, rsp_illegal=1, rsp_result=0.
- Signed/unsigned: req0 slt a=0xFFFF_FFFF, b=1 → rsp_result=1; then sltu with the same operands → rsp_result=0.
- Reset mid-stream: assert rst_n=0 while FULL and both requesters valid → next cycle rsp_valid=0, readys 0; after release, req0 is granted first.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// with a single registered response slot and valid/ready on every side.
module alu_share_arbiter #(
  parameter int unsigned OPERAND_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [3:0]               req0_op,
  input  logic [OPERAND_WIDTH-1:0] req0_a,
  input  logic [OPERAND_WIDTH-1:0] req0_b,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [3:0]               req1_op,
  input  logic [OPERAND_WIDTH-1:0] req1_a,
  input  logic [OPERAND_WIDTH-1:0] req1_b,
  output logic [3:0]               alu_op,
  output logic [OPERAND_WIDTH-1:0] alu_operand1,
  output logic [OPERAND_WIDTH-1:0] alu_operand2,
  input  logic [OPERAND_WIDTH-1:0] alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [OPERAND_WIDTH-1:0] rsp_result,
  output logic                     rsp_illegal
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;
  localparam logic [3:0] OP_MAX   = 4'b1001;

  logic [0:0]               state_q, state_d;
  logic                     rsp_id_q, rsp_id_d;
  logic [OPERAND_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                     rsp_illegal_q, rsp_illegal_d;
  logic                     ptr_q, ptr_d;

  logic                     can_accept;
  logic                     gnt;
  logic                     gnt_idx;
  logic                     sel_illegal;

  // Arbitration, ALU drive and next-state; ready never depends on a ready output.
  always_comb begin
    state_d       = state_q;
    rsp_id_d      = rsp_id_q;
    rsp_result_d  = rsp_result_q;
    rsp_illegal_d = rsp_illegal_q;
    ptr_d         = ptr_q;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    alu_op        = 4'b0000;
    alu_operand1  = '0;
    alu_operand2  = '0;
    sel_illegal   = 1'b0;

    can_accept = (state_q == ST_EMPTY) || rsp_ready;
    gnt        = can_accept && rst_n && (req0_valid || req1_valid);
    gnt_idx    = (req0_valid && req1_valid) ? ptr_q : req1_valid;

    if (gnt) begin
      req0_ready = !gnt_idx;
      req1_ready = gnt_idx;
      if (gnt_idx) begin
        alu_op       = req1_op;
        alu_operand1 = req1_a;
        alu_operand2 = req1_b;
      end else begin
        alu_op       = req0_op;
        alu_operand1 = req0_a;
        alu_operand2 = req0_b;
      end
      sel_illegal   = alu_op > OP_MAX;
      state_d       = ST_FULL;
      rsp_id_d      = gnt_idx;
      rsp_illegal_d = sel_illegal;
      rsp_result_d  = sel_illegal ? '0 : alu_result;
      ptr_d         = ~gnt_idx;
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_EMPTY;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= '0;
      rsp_illegal_q <= 1'b0;
      ptr_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rsp_id_q      <= rsp_id_d;
      rsp_result_q  <= rsp_result_d;
      rsp_illegal_q <= rsp_illegal_d;
      ptr_q         <= ptr_d;
    end
  end

  assign rsp_valid   = (state_q == ST_FULL);
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule
